// File: rtl/cla_nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial CLA adder: FSM encodings and slice width.
package cla_nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/cla_nibble_serial_adder_slice4.sv
// Purely combinational 4-bit carry-lookahead slice with group propagate/generate.
module cla_nibble_serial_adder_slice4
  import cla_nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_ci,
  output logic [NIB_W-1:0] o_s,
  output logic             o_co,
  output logic             o_pg,
  output logic             o_gg
);

  logic [NIB_W-1:0] w_p;
  logic [NIB_W-1:0] w_g;
  logic [NIB_W:0]   w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Every carry is expanded directly from i_ci, so there is no ripple through the slice.
  assign w_c[0] = i_ci;
  assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_ci);
  assign w_c[4] = o_gg | (o_pg & i_ci);

  assign o_pg = &w_p;
  assign o_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

  assign o_s  = w_p ^ w_c[NIB_W-1:0];
  assign o_co = w_c[4];

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle adder: one 4-bit CLA slice reused per nibble, LSB first, with
// word-level PG/GG accumulated across passes and valid/ready on both sides.
//
// state   | meaning
// IDLE    | in_ready high, waiting for an operand pair
// RUN     | one nibble per cycle through the slice, carry held in r_c
// DONE    | result held on outputs until out_ready
module cla_nibble_serial_adder
  import cla_nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_pg,
  output logic             o_gg
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = $clog2(NIB);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum_sh;
  logic               r_c;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pg_acc;
  logic               r_gg_acc;

  logic [NIB_W-1:0]   w_s;
  logic               w_co;
  logic               w_pg;
  logic               w_gg;

  cla_nibble_serial_adder_slice4 u_cla_slice4 (
    .i_a  (r_a_sh[NIB_W-1:0]),
    .i_b  (r_b_sh[NIB_W-1:0]),
    .i_ci (r_c),
    .o_s  (w_s),
    .o_co (w_co),
    .o_pg (w_pg),
    .o_gg (w_gg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_pg_acc <= 1'b0;
      r_gg_acc <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_a_sh   <= i_a;
            r_b_sh   <= i_b;
            r_c      <= i_cin;
            r_cnt    <= '0;
            r_pg_acc <= 1'b1;
            r_gg_acc <= 1'b0;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_c      <= w_co;
          r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:NIB_W]};
          r_a_sh   <= r_a_sh >> NIB_W;
          r_b_sh   <= r_b_sh >> NIB_W;
          r_pg_acc <= w_pg & r_pg_acc;
          // Higher nibble's generate wins; otherwise it passes the lower group's generate through.
          r_gg_acc <= w_gg | (w_pg & r_gg_acc);
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(NIB - 1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_out_valid = (r_state == ST_DONE);
  assign o_sum       = r_sum_sh;
  assign o_cout      = r_c;
  assign o_pg        = r_pg_acc;
  assign o_gg        = r_gg_acc;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Bench for the nibble-serial CLA adder: arithmetic reference model plus directed literals.
module tb_cla_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          pg;
  logic          gg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  cla_nibble_serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (in_a),
    .i_b         (in_b),
    .i_cin       (in_cin),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_sum       (sum),
    .o_cout      (cout),
    .o_pg        (pg),
    .o_gg        (gg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: {cout,sum} is plain a+b+cin; gg is the carry out of a+b alone; pg is all bits propagating.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] full;
    logic [W:0] nocin;
    full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    nocin = {1'b0, a} + {1'b0, b};
    return {full[W-1:0], full[W], &(a ^ b), nocin[W]};
  endfunction

  logic [W+2:0] exp_q[$];
  logic [W+2:0] held;
  logic [W+2:0] e;
  logic         prev_ov = 1'b0;
  int           acc_edge = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_ov = 1'b0;
    end else begin
      chk("ready_valid_excl", {31'b0, in_ready & out_valid}, 32'd0);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_cin));
        acc_edge = cyc + 1;
      end
      if (out_valid) begin
        if (!prev_ov) chk("latency", cyc - acc_edge, NIB);
        else          chk("hold_stable", {13'b0, sum, cout, pg, gg}, {13'b0, held});
        held = {sum, cout, pg, gg};
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("model_result", {13'b0, sum, cout, pg, gg}, {13'b0, e});
          end
        end
        prev_ov = !out_ready;
      end else begin
        prev_ov = 1'b0;
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int gap, input int hold,
                       output logic [W-1:0] s, output logic co, output logic p, output logic g);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!out_valid) chk("result_timeout", 32'd1, 32'd0);
    s = sum; co = cout; p = pg; g = gg;
    repeat (hold) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); in_a = W'($urandom); in_b = W'($urandom);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("idle_after_take", {30'b0, in_ready, out_valid}, 32'd2);
  endtask

  logic [W-1:0] s;
  logic         co, p, g;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {11'b0, in_ready, out_valid, sum, cout, pg, gg}, {11'b0, 1'b1, 1'b0, 16'h0, 3'b000});
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'h1234, 16'h4321, 1'b0, 0, 0, s, co, p, g);
    chk("d_1234_4321", {13'b0, s, co, p, g}, {13'b0, 16'h5555, 3'b000});
    do_op(16'hFFFF, 16'h0001, 1'b0, 1, 0, s, co, p, g);
    chk("d_ffff_0001", {13'b0, s, co, p, g}, {13'b0, 16'h0000, 3'b101});
    do_op(16'hAAAA, 16'h5555, 1'b1, 0, 0, s, co, p, g);
    chk("d_aaaa_5555_c1", {13'b0, s, co, p, g}, {13'b0, 16'h0000, 3'b110});
    do_op(16'hAAAA, 16'h5555, 1'b0, 0, 0, s, co, p, g);
    chk("d_aaaa_5555_c0", {13'b0, s, co, p, g}, {13'b0, 16'hFFFF, 3'b010});
    do_op(16'h8001, 16'h8001, 1'b0, 0, 5, s, co, p, g);
    chk("d_backpressure", {13'b0, s, co, p, g}, {13'b0, 16'h0002, 3'b101});

    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_run", {11'b0, in_ready, out_valid, sum, cout, pg, gg}, {11'b0, 1'b1, 1'b0, 16'h0, 3'b000});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h0F0F, 16'h00F1, 1'b0, 0, 0, s, co, p, g);
    chk("d_after_reset", {13'b0, s, co}, {13'b0, 16'h1000, 1'b0});

    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ~ra : W'($urandom);
      do_op(ra, rb, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), s, co, p, g);
    end

    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
